// File: rtl/fxp_mac_stream_if.sv
// fxp_mac_stream_if: operand-beat and result handshake bundle for fxp_mac_stream
interface fxp_mac_stream_if #(parameter int N = 8);
  logic in_valid;
  logic in_ready;
  logic signed [N-1:0] in_a;
  logic signed [N-1:0] in_b;
  logic in_last;
  logic out_valid;
  logic out_ready;
  logic signed [N-1:0] out_y;
  logic out_sat;
  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_y, out_sat
  );
  modport master (
    output in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_y, out_sat
  );
endinterface

// File: rtl/fxp_mac_stream.sv
// fxp_mac_stream: streaming signed MAC with saturating N-bit requantization.
// Define FXP_MAC_ROUND_EN for round-half-up requantization instead of truncation.
module fxp_mac_stream #(
  parameter int N     = 8,
  parameter int FRAC  = 4,
  parameter int ACC_W = 24
) (
  input logic clk,
  input logic rst_n,
  fxp_mac_stream_if.slave s
);
  localparam logic signed [N-1:0]     Y_MAX   = {1'b0, {(N-1){1'b1}}};
  localparam logic signed [N-1:0]     Y_MIN   = {1'b1, {(N-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`ifdef FXP_MAC_ROUND_EN
  localparam logic [ACC_W:0] RND = (FRAC > 0) ? (ACC_W+1)'(1) << (FRAC > 0 ? FRAC - 1 : 0) : '0;
`endif
  logic signed [2*N-1:0] p_q, p_d;
  logic p_valid_q, p_valid_d, p_last_q, p_last_d, last_pending_q, last_pending_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, acc_next;
  logic sat_acc_q, sat_acc_d;
  logic out_valid_q, out_valid_d, out_sat_q, out_sat_d;
  logic signed [N-1:0] out_y_q, out_y_d, y_clamped;
  logic signed [ACC_W:0] sum, rq, r;
  logic [ACC_W-N+1:0] r_hi;
  logic accept, acc_ovf, y_fit;
  assign s.in_ready  = !last_pending_q && !out_valid_q;
  assign s.out_valid = out_valid_q;
  assign s.out_y     = out_y_q;
  assign s.out_sat   = out_sat_q;
  always_comb begin
    accept         = s.in_valid && s.in_ready;
    p_valid_d      = accept;
    p_d            = accept ? (2*N)'(s.in_a) * (2*N)'(s.in_b) : p_q;
    p_last_d       = accept ? s.in_last : p_last_q;
    last_pending_d = accept && s.in_last;
    sum            = {acc_q[ACC_W-1], acc_q} + (ACC_W+1)'(p_q);
    acc_ovf        = sum[ACC_W] ^ sum[ACC_W-1];
    acc_next       = acc_ovf ? (sum[ACC_W] ? ACC_MIN : ACC_MAX) : sum[ACC_W-1:0];
`ifdef FXP_MAC_ROUND_EN
    rq             = {acc_next[ACC_W-1], acc_next} + RND;
`else
    rq             = {acc_next[ACC_W-1], acc_next};
`endif
    r              = rq >>> FRAC;
    // r fits in N bits when every bit from N-1 upward equals the sign
    r_hi           = r[ACC_W:N-1];
    y_fit          = (&r_hi) || !(|r_hi);
    y_clamped      = y_fit ? r[N-1:0] : (r[ACC_W] ? Y_MIN : Y_MAX);
    acc_d          = p_valid_q ? (p_last_q ? '0 : acc_next) : acc_q;
    sat_acc_d      = p_valid_q ? (!p_last_q && (sat_acc_q || acc_ovf)) : sat_acc_q;
    out_valid_d    = (p_valid_q && p_last_q) || (out_valid_q && !s.out_ready);
    out_y_d        = (p_valid_q && p_last_q) ? y_clamped : out_y_q;
    out_sat_d      = (p_valid_q && p_last_q) ? (sat_acc_q || acc_ovf || !y_fit) : out_sat_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_q            <= '0;
      p_valid_q      <= 1'b0;
      p_last_q       <= 1'b0;
      last_pending_q <= 1'b0;
      acc_q          <= '0;
      sat_acc_q      <= 1'b0;
      out_valid_q    <= 1'b0;
      out_y_q        <= '0;
      out_sat_q      <= 1'b0;
    end else begin
      p_q            <= p_d;
      p_valid_q      <= p_valid_d;
      p_last_q       <= p_last_d;
      last_pending_q <= last_pending_d;
      acc_q          <= acc_d;
      sat_acc_q      <= sat_acc_d;
      out_valid_q    <= out_valid_d;
      out_y_q        <= out_y_d;
      out_sat_q      <= out_sat_d;
    end
  end
endmodule

// File: tb/tb_fxp_mac_stream.sv
// tb_fxp_mac_stream: directed vectors with hand-computed results for fxp_mac_stream.
module tb_fxp_mac_stream;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_err = 0;
  fxp_mac_stream_if #(.N(8)) bus ();
  fxp_mac_stream #(.N(8), .FRAC(4), .ACC_W(24)) dut (.clk(clk), .rst_n(rst_n), .s(bus.slave));
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask
  task automatic beat(input int a, input int b, input bit l);
    int n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("beat_ready_timeout", 0, 1);
    bus.in_valid = 1'b1;
    bus.in_a = 8'(a);
    bus.in_b = 8'(b);
    bus.in_last = l;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask
  task automatic result(input string tag, input int y, input int sat);
    int n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, int'(bus.out_valid), 1);
    check({tag, "_y"}, int'(bus.out_y), y);
    check({tag, "_sat"}, int'(bus.out_sat), sat);
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_y", int'(bus.out_y), 0);
    check("rst_out_sat", int'(bus.out_sat), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", int'(bus.in_ready), 1);
    beat(16, 16, 1);
    @(negedge clk);
    check("lat1_in_ready", int'(bus.in_ready), 0);
    check("lat1_out_valid", int'(bus.out_valid), 0);
    @(negedge clk);
    check("lat2_out_valid", int'(bus.out_valid), 1);
    check("lat2_in_ready", int'(bus.in_ready), 0);
    check("lat2_y", int'(bus.out_y), 16);
    check("lat2_sat", int'(bus.out_sat), 0);
    @(negedge clk);
    check("lat3_out_valid", int'(bus.out_valid), 0);
    check("lat3_in_ready", int'(bus.in_ready), 1);
    beat(10, 20, 0);
    beat(-5, 8, 0);
    beat(3, 3, 1);
`ifdef FXP_MAC_ROUND_EN
    result("three", 11, 0);
`else
    result("three", 10, 0);
`endif
    for (int i = 0; i < 4; i++) beat(127, 127, i == 3);
    result("pos_sat", 127, 1);
    for (int i = 0; i < 4; i++) beat(-128, 127, i == 3);
    result("neg_sat", -128, 1);
    bus.out_ready = 1'b0;
    beat(1, 16, 1);
    result("bp_first", 1, 0);
    bus.in_valid = 1'b1;
    bus.in_a = 8'(50);
    bus.in_b = 8'(50);
    bus.in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_valid", int'(bus.out_valid), 1);
      check("bp_hold_y", int'(bus.out_y), 1);
      check("bp_hold_sat", int'(bus.out_sat), 0);
      check("bp_in_ready", int'(bus.in_ready), 0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release_in_ready", int'(bus.in_ready), 1);
    check("bp_release_out_valid", int'(bus.out_valid), 0);
    beat(3, 16, 0);
    beat(1, 16, 1);
    result("bp_next", 4, 0);
    beat(-1, 1, 1);
`ifdef FXP_MAC_ROUND_EN
    result("neg_round", 0, 0);
`else
    result("neg_round", -1, 0);
`endif
    beat(7, 16, 1);
    result("pre_rst", 7, 0);
    beat(100, 100, 0);
    beat(100, 100, 0);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", int'(bus.out_valid), 0);
    check("midrst_out_y", int'(bus.out_y), 0);
    check("midrst_out_sat", int'(bus.out_sat), 0);
    check("midrst_in_ready", int'(bus.in_ready), 1);
    beat(2, 8, 1);
    result("post_rst", 1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
